// File: rtl/aes_axil_ctrl_regbank.sv
// AXI4-Lite register bank in front of an AES encrypt core: key/plaintext/ciphertext words, start, status.
// Optional build macro AES_IRQ_EN adds a registered irq output and the CTRL.IRQ_EN bit.
module aes_axil_ctrl_regbank #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 7,
  parameter int unsigned KEY_WORDS          = 8,
  parameter int unsigned BLK_WORDS          = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*KEY_WORDS-1:0] core_key,
  output logic [C_S_AXI_DATA_WIDTH*BLK_WORDS-1:0] core_din,
  output logic                                   core_start,
  input  logic                                   core_done,
  input  logic [C_S_AXI_DATA_WIDTH*BLK_WORDS-1:0] core_dout
`ifdef AES_IRQ_EN
  ,
  output logic                                   irq
`endif
);

  localparam int unsigned DW         = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW         = DW / 8;
  localparam int unsigned CTRL_IDX   = 0;
  localparam int unsigned STATUS_IDX = 1;
  localparam int unsigned KEY_BASE   = 2;
  localparam int unsigned DIN_BASE   = KEY_BASE + KEY_WORDS;
  localparam int unsigned DOUT_BASE  = DIN_BASE + BLK_WORDS;
  localparam int unsigned MAP_WORDS  = DOUT_BASE + BLK_WORDS;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic                    aw_w_ready_q;
  logic                    bvalid_q;
  logic [1:0]              bresp_q;
  logic                    arready_q;
  logic                    rvalid_q;
  logic [1:0]              rresp_q;
  logic [DW-1:0]           rdata_q;

  logic [DW*KEY_WORDS-1:0] key_q;
  logic [DW*BLK_WORDS-1:0] din_q;
  logic [DW*BLK_WORDS-1:0] dout_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    start_q;
  logic                    irq_en_q;

  logic                    wr_en;
  logic                    rd_en;
  logic [31:0]             wr_word;
  logic [31:0]             rd_word;
  logic                    wr_is_key;
  logic                    wr_is_din;
  logic                    wr_data_ok;
  logic                    start_go;
  logic                    done_clear;
  logic                    core_finish;
  logic [1:0]              wr_resp_c;
  logic [DW-1:0]           rd_data_c;
  logic [1:0]              rd_resp_c;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] cur,
                                               input logic [DW-1:0] data,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = cur;
    for (int unsigned b = 0; b < SW; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  assign wr_en       = aw_w_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en       = arready_q & S_AXI_ARVALID;
  assign wr_word     = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign rd_word     = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign wr_is_key   = (wr_word >= KEY_BASE) && (wr_word < DIN_BASE);
  assign wr_is_din   = (wr_word >= DIN_BASE) && (wr_word < DOUT_BASE);
  assign wr_data_ok  = wr_en && !busy_q;
  assign start_go    = wr_en && (wr_word == CTRL_IDX) && S_AXI_WDATA[0] && !busy_q;
  assign done_clear  = wr_en && (wr_word == STATUS_IDX) && S_AXI_WDATA[1];
  assign core_finish = core_done && busy_q;

  // Key/DIN writes are refused while the core is consuming them
  always_comb begin
    wr_resp_c = RESP_OKAY;
    if ((wr_word >= MAP_WORDS) || ((wr_is_key || wr_is_din) && busy_q)) begin
      wr_resp_c = RESP_SLVERR;
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    if (rd_word == CTRL_IDX) begin
`ifdef AES_IRQ_EN
      rd_data_c[1] = irq_en_q;
`endif
    end else if (rd_word == STATUS_IDX) begin
      rd_data_c[1:0] = {done_q, busy_q};
    end else if (rd_word >= MAP_WORDS) begin
      rd_resp_c = RESP_SLVERR;
    end else begin
      for (int unsigned k = 0; k < BLK_WORDS; k++) begin
        if (rd_word == DIN_BASE + k)  rd_data_c = din_q[DW*k +: DW];
        if (rd_word == DOUT_BASE + k) rd_data_c = dout_q[DW*k +: DW];
      end
    end
  end

  // AXI handshake and response registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_w_ready_q <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
    end else begin
      aw_w_ready_q <= !aw_w_ready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
      arready_q    <= !arready_q && S_AXI_ARVALID && !rvalid_q;
      if (wr_en) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp_c;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_resp_c;
        rdata_q  <= rd_data_c;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Register file, start pulse and completion capture
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      key_q    <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      start_q <= start_go;
      if (start_go) begin
        busy_q <= 1'b1;
      end else if (core_finish) begin
        busy_q <= 1'b0;
      end
      if (core_finish) begin
        dout_q <= core_dout;
        done_q <= 1'b1;
      end else if (done_clear) begin
        done_q <= 1'b0;
      end
`ifdef AES_IRQ_EN
      if (wr_en && (wr_word == CTRL_IDX) && S_AXI_WSTRB[0]) begin
        irq_en_q <= S_AXI_WDATA[1];
      end
`endif
      for (int unsigned k = 0; k < KEY_WORDS; k++) begin
        if (wr_data_ok && (wr_word == KEY_BASE + k)) begin
          key_q[DW*k +: DW] <= byte_merge(key_q[DW*k +: DW], S_AXI_WDATA, S_AXI_WSTRB);
        end
      end
      for (int unsigned k = 0; k < BLK_WORDS; k++) begin
        if (wr_data_ok && (wr_word == DIN_BASE + k)) begin
          din_q[DW*k +: DW] <= byte_merge(din_q[DW*k +: DW], S_AXI_WDATA, S_AXI_WSTRB);
        end
      end
    end
  end

`ifdef AES_IRQ_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) irq <= 1'b0;
    else          irq <= done_q & irq_en_q;
  end
`else
  logic unused_irq_en;
  assign unused_irq_en = irq_en_q;
`endif

  assign S_AXI_AWREADY = aw_w_ready_q;
  assign S_AXI_WREADY  = aw_w_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign core_key      = key_q;
  assign core_din      = din_q;
  assign core_start    = start_q;

endmodule

// File: tb/tb_aes_axil_ctrl_regbank.sv
// Scoreboard bench for aes_axil_ctrl_regbank; build with +define+AES_IRQ_EN to exercise irq.
module tb_aes_axil_ctrl_regbank;

  localparam int unsigned KW     = 8;
  localparam int unsigned BW     = 4;
  localparam int unsigned DIN_W  = 2 + KW;
  localparam int unsigned DOUT_W = DIN_W + BW;
  localparam int unsigned MAP_W  = DOUT_W + BW;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
`ifdef AES_IRQ_EN
  localparam logic [31:0] CTRL_RB = 32'h2;
`else
  localparam logic [31:0] CTRL_RB = 32'h0;
`endif

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic [6:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [6:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [255:0] core_key;
  logic [127:0] core_din;
  logic         core_start;
  logic         core_done;
  logic [127:0] core_dout;
`ifdef AES_IRQ_EN
  logic         irq;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int start_cnt   = 0;
  int start_cyc   = 0;

  logic [1:0]   wq[$];
  logic [33:0]  rq[$];
  logic [255:0] exp_key;
  logic [127:0] exp_din;
  logic [127:0] ct1;
  logic [127:0] ct2;

  aes_axil_ctrl_regbank dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .core_key(core_key), .core_din(core_din), .core_start(core_start),
    .core_done(core_done), .core_dout(core_dout)
`ifdef AES_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (core_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  // All tasks start and end 1 time unit after a rising edge
  task automatic axi_write(input int word, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp);
    int n;
    logic [1:0] e;
    wq.push_back(exp_resp);
    S_AXI_AWADDR = 7'(word * 4); S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    while (S_AXI_AWREADY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    while (S_AXI_BVALID !== 1'b1 && n < 40) begin @(posedge ACLK); #1; n++; end
    e = wq.pop_front();
    vectors++;
    if (S_AXI_BRESP !== e || n >= 20) begin
      miscompares++;
      $display("FAIL write[%0d] bresp: got %0d (bvalid %b, waited %0d) expected %0d", word, S_AXI_BRESP, S_AXI_BVALID, n, e);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input int word, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    logic [33:0] e;
    rq.push_back({exp_data, exp_resp});
    S_AXI_ARADDR = 7'(word * 4); S_AXI_ARVALID = 1'b1;
    n = 0;
    while (S_AXI_ARREADY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    while (S_AXI_RVALID !== 1'b1 && n < 40) begin @(posedge ACLK); #1; n++; end
    e = rq.pop_front();
    vectors++;
    if ({S_AXI_RDATA, S_AXI_RRESP} !== e || n >= 20) begin
      miscompares++;
      $display("FAIL read[%0d]: got data %h resp %0d (waited %0d) expected data %h resp %0d", word, S_AXI_RDATA, S_AXI_RRESP, n, e[33:2], e[1:0]);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic pulse_done(input logic [127:0] dout);
    core_dout = dout; core_done = 1'b1;
    @(posedge ACLK); #1;
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    vectors++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
         S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, core_start, core_key, core_din} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got bvalid %b rvalid %b awready %b arready %b rdata %h start %b expected all 0",
               S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_RDATA, core_start);
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    for (int w = 0; w < int'(MAP_W); w++) axi_read(w, 32'h0, OKAY);
  endtask

  task automatic test_reset_mid_read();
    int n;
    S_AXI_RREADY = 1'b0; S_AXI_ARADDR = 7'h4; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (S_AXI_ARREADY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    vectors++;
    if (S_AXI_RVALID !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_read rvalid before reset: got %b expected 1", S_AXI_RVALID);
    end
    #2 ARESETN = 1'b0;
    #1;
    vectors++;
    if (S_AXI_RVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_read rvalid in reset: got %b expected 0", S_AXI_RVALID);
    end
    @(posedge ACLK); #1;
    ARESETN = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
  endtask

  task automatic test_load_and_start();
    logic [31:0] kw;
    for (int i = 0; i < int'(KW); i++) begin
      kw = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      exp_key[32*i +: 32] = kw;
      axi_write(2 + i, kw, 4'hF, OKAY);
    end
    exp_din = 128'hCCDDEEFF_8899AABB_44556677_00112233;
    for (int i = 0; i < int'(BW); i++) axi_write(int'(DIN_W) + i, exp_din[32*i +: 32], 4'hF, OKAY);
    vectors++;
    if (core_key !== exp_key || core_din !== exp_din) begin
      miscompares++;
      $display("FAIL core_key/din: got %h / %h expected %h / %h", core_key, core_din, exp_key, exp_din);
    end
    axi_read(2, 32'h0, OKAY);
    axi_read(int'(DIN_W) + 3, 32'hCCDDEEFF, OKAY);
    start_cnt = 0;
    axi_write(0, 32'h1, 4'hF, OKAY);
    axi_read(1, 32'h1, OKAY);
    axi_read(0, 32'h0, OKAY);
    vectors++;
    if (start_cnt !== 1) begin
      miscompares++;
      $display("FAIL start pulse count: got %0d expected 1", start_cnt);
    end
  endtask

  task automatic test_done();
    int n;
    n = 0;
    while (cyc < start_cyc + 14 && n < 40) begin @(posedge ACLK); #1; n++; end
    pulse_done(ct1);
    axi_read(1, 32'h2, OKAY);
    for (int i = 0; i < int'(BW); i++) axi_read(int'(DOUT_W) + i, ct1[32*i +: 32], OKAY);
    axi_write(1, 32'h2, 4'hF, OKAY);
    axi_read(1, 32'h0, OKAY);
    pulse_done(~ct1);
    axi_read(1, 32'h0, OKAY);
    axi_read(int'(DOUT_W), ct1[31:0], OKAY);
  endtask

  task automatic test_busy_errors();
    axi_write(0, 32'h1, 4'hF, OKAY);
    axi_write(2, 32'hFFFFFFFF, 4'hF, SLVERR);
    axi_write(int'(DIN_W), 32'hFFFFFFFF, 4'hF, SLVERR);
    vectors++;
    if (core_key !== exp_key || core_din !== exp_din) begin
      miscompares++;
      $display("FAIL busy write leak: got key %h din %h expected %h / %h", core_key, core_din, exp_key, exp_din);
    end
    axi_write(0, 32'h1, 4'hF, OKAY);
    axi_write(1, 32'h1, 4'hF, OKAY);
    axi_write(int'(DOUT_W), 32'h12345678, 4'hF, OKAY);
    axi_read(1, 32'h1, OKAY);
    axi_read(int'(DOUT_W), ct1[31:0], OKAY);
    vectors++;
    if (start_cnt !== 2) begin
      miscompares++;
      $display("FAIL start while busy: got %0d pulses expected 2", start_cnt);
    end
    pulse_done(ct2);
    axi_read(1, 32'h2, OKAY);
    axi_read(int'(DOUT_W), ct2[31:0], OKAY);
    axi_write(1, 32'h2, 4'hF, OKAY);
  endtask

  task automatic test_map_errors();
    axi_read(int'(MAP_W), 32'h0, SLVERR);
    axi_read(31, 32'h0, SLVERR);
    axi_write(int'(MAP_W), 32'hFFFFFFFF, 4'hF, SLVERR);
    axi_write(0, 32'h2, 4'hF, OKAY);
    axi_read(0, CTRL_RB, OKAY);
    axi_write(0, 32'h0, 4'hF, OKAY);
    axi_write(int'(DIN_W), 32'hDEADBEEF, 4'b0010, OKAY);
    exp_din[15:8] = 8'hBE;
    axi_read(int'(DIN_W), 32'h0011BE33, OKAY);
    vectors++;
    if (core_din !== exp_din) begin
      miscompares++;
      $display("FAIL strobe core_din: got %h expected %h", core_din, exp_din);
    end
  endtask

  task automatic test_bready_stall();
    int n;
    logic [1:0] e;
    S_AXI_BREADY = 1'b0;
    wq.push_back(OKAY);
    S_AXI_AWADDR = 7'((DIN_W + 1) * 4); S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    while (S_AXI_AWREADY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 7'((DIN_W + 2) * 4); S_AXI_WDATA = 32'h5A5A5A5A;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0) begin
        miscompares++;
        $display("FAIL bready stall cycle %0d: got bvalid %b awready %b expected 1 0", i, S_AXI_BVALID, S_AXI_AWREADY);
      end
      @(posedge ACLK); #1;
    end
    e = wq.pop_front();
    vectors++;
    if (S_AXI_BRESP !== e) begin
      miscompares++;
      $display("FAIL bready stall bresp: got %0d expected %0d", S_AXI_BRESP, e);
    end
    S_AXI_BREADY = 1'b1;
    wq.push_back(OKAY);
    n = 0;
    while (S_AXI_AWREADY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    e = wq.pop_front();
    vectors++;
    if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== e || n >= 20) begin
      miscompares++;
      $display("FAIL second write after stall: got bvalid %b bresp %0d expected 1 %0d", S_AXI_BVALID, S_AXI_BRESP, e);
    end
    @(posedge ACLK); #1;
    axi_read(int'(DIN_W) + 1, 32'hA5A5A5A5, OKAY);
    axi_read(int'(DIN_W) + 2, 32'h5A5A5A5A, OKAY);
  endtask

`ifdef AES_IRQ_EN
  task automatic test_irq();
    int n;
    logic [1:0] e;
    axi_write(0, 32'h3, 4'hF, OKAY);
    pulse_done(ct1);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq same cycle as done: got %b expected 0", irq);
    end
    @(posedge ACLK); #1;
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq one cycle after done: got %b expected 1", irq);
    end
    axi_write(0, 32'h3, 4'hF, OKAY);
    wq.push_back(OKAY);
    S_AXI_AWADDR = 7'h4; S_AXI_WDATA = 32'h2; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    while (S_AXI_AWREADY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
    core_dout = ct2; core_done = 1'b1;
    @(posedge ACLK); #1;
    core_done = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    e = wq.pop_front();
    vectors++;
    if (S_AXI_BRESP !== e || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL w1c vs done: got bresp %0d irq %b expected %0d 1", S_AXI_BRESP, irq, e);
    end
    @(posedge ACLK); #1;
    axi_read(1, 32'h2, OKAY);
    axi_read(int'(DOUT_W), ct2[31:0], OKAY);
    axi_write(1, 32'h2, 4'hF, OKAY);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq after clear: got %b expected 0", irq);
    end
  endtask
`endif

  initial begin
    ct1 = 128'h8EA2B7CA_516745BF_EAFC4990_4B496089;
    ct2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    exp_key = '0; exp_din = '0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = 3'b0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'b0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    core_done = 1'b0; core_dout = '0;
    test_reset();
    test_reset_mid_read();
    test_load_and_start();
    test_done();
    test_busy_errors();
    test_map_errors();
    test_bready_stall();
`ifdef AES_IRQ_EN
    test_irq();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_axil_ctrl_regbank.md
Name: aes_axil_ctrl_regbank

Overview:
Parametrised AXI4-Lite slave register bank that fronts an AES encrypt core. It replaces the fixed 4-register slave interface. Holds key and plaintext words and drives a start pulse. Captures the ciphertext on core done and reports busy/done status. Sits between the AXI interconnect (Vivado BD master) and the AES datapath inside the IP wrapper.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 7, byte address width; must cover 2+KEY_WORDS+2*BLK_WORDS words.
KEY_WORDS, 8, 32-bit key words (8 = AES-256, 6 = AES-192, 4 = AES-128).
BLK_WORDS, 4, 32-bit words per data block.

Ports:
ACLK  in  1  single clock for all logic.
ARESETN  in  1  asynchronous active-low reset.
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR/3/1/1  AXI4-Lite write address channel.
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR/3/1/1  read address channel.
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.
core_key  out  32*KEY_WORDS  key; word 0 in the LSBs.
core_din  out  32*BLK_WORDS  plaintext block.
core_start  out  1  one-cycle start pulse.
core_done  in  1  one-cycle pulse; core_dout is valid in the same cycle.
core_dout  in  32*BLK_WORDS  ciphertext block.
irq  out  1  present only with AES_IRQ_EN.

Behaviour:
- Word map, byte address = 4*index:
  - 0 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN (R/W).
  - 1 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear).
  - 2..2+KEY_WORDS-1 KEY (write-only, reads 0).
  - next BLK_WORDS: DIN (R/W).
  - next BLK_WORDS: DOUT (RO).
- Reset (async, ARESETN=0): all ready/valid outputs 0, BRESP/RRESP=0, RDATA=0. All registers 0, BUSY=0, DONE=0, core_start=0, irq=0. Takes effect immediately, including mid-transaction or mid-encryption. A core_done arriving after reset release is ignored unless BUSY=1.
- Write channel:
  - AWREADY and WREADY assert together for one cycle when AWVALID & WVALID & !BVALID.
  - Write commits on that cycle; BVALID rises the next cycle and holds until BREADY.
  - Only one outstanding write; AW-without-W waits and AW is not accepted alone.
  - WSTRB byte enables apply to CTRL[1], KEY and DIN.
- Read channel:
  - ARREADY pulses one cycle when ARVALID & !RVALID.
  - RVALID and RDATA follow the next cycle, held until RREADY.
  - Read latency is 2 cycles ARVALID-to-RVALID minimum.
- Errors:
  - Address beyond the map: write ignored with BRESP=SLVERR(2); read returns RDATA=0 with RRESP=SLVERR.
  - KEY or DIN write while BUSY=1: ignored, SLVERR.
  - Writes to STATUS bit0 or to DOUT: ignored, OKAY.
- Start:
  - START=1 written while BUSY=0: core_start=1 the next cycle for exactly 1 cycle; BUSY=1 in the same cycle as core_start.
  - START written while BUSY=1: ignored, OKAY.
- Done:
  - core_done while BUSY=1: DOUT<=core_dout, BUSY<=0, DONE<=1, all registered (visible the next cycle).
  - core_done while BUSY=0: ignored.
- Simultaneous events:
  - DONE W1C in the same cycle as core_done: set wins, DONE=1.
  - START write in the same cycle as core_done: START is ignored, since BUSY is still 1 that cycle.
- core_key and core_din are direct register outputs, stable while BUSY=1.
- AWPROT/ARPROT are ignored.

Optional Feature:
AES_IRQ_EN:
- Defined: port irq exists and is registered. irq = DONE & IRQ_EN; it stays high until DONE is cleared or IRQ_EN is written 0.
- Undefined: no irq port; CTRL bit1 reads 0 and writes to it are ignored. All other behaviour is unchanged.

Test Plan:
1. Reset then read all words -> RDATA=0, RRESP=OKAY; BVALID/RVALID low during reset; ARESETN low mid-read drops RVALID immediately.
2. Write KEY[0..7]=0x00010203..0x1C1D1E1F and DIN[0..3]=0x00112233..0xCCDDEEFF, then CTRL=1 -> single core_start pulse; STATUS=0x1; core_key/core_din match the written words.
3. Core model returns core_done with dout 0x8EA2B7CA_516745BF_EAFC4990_4B496089 after 14 cycles -> STATUS=0x2; DOUT words read back exactly; write STATUS=0x2 -> STATUS=0x0.
4. While BUSY, write KEY[0]=0xFFFFFFFF -> BRESP=SLVERR and core_key unchanged. Write CTRL=1 while BUSY -> no second core_start.
5. Read/write word index 2+KEY_WORDS+2*BLK_WORDS -> SLVERR, RDATA=0. WSTRB=4'b0010 on DIN[0] updates byte 1 only. Hold BREADY low 5 cycles -> BVALID held and no new AW accepted.
6. With AES_IRQ_EN: set IRQ_EN, run an encryption -> irq rises 1 cycle after DONE; W1C in the same cycle as a second core_done leaves DONE=1 and irq=1.
